// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, registered read port, status flags and occupancy counts
// Optional simulation checks enabled by defining SYNC_FIFO_ASSERT_EN.
module sync_fifo #(
  parameter int DEPTH             = 2048,
  parameter int WIDTH             = 32,
  parameter int PROG_FULL_THRESH  = 10,
  parameter int PROG_EMPTY_THRESH = 10,
  parameter int CNT_WIDTH         = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     din,
  output logic                 full,
  output logic                 almost_full,
  output logic                 prog_full,
  output logic                 wr_ack,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] wr_data_count,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     dout,
  output logic                 data_valid,
  output logic                 empty,
  output logic                 almost_empty,
  output logic                 prog_empty,
  output logic                 underflow,
  output logic [CNT_WIDTH-1:0] rd_data_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AFULL_C = CNT_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] PFULL_C = CNT_WIDTH'(PROG_FULL_THRESH);
  localparam logic [CNT_WIDTH-1:0] PEMPTY_C = CNT_WIDTH'(PROG_EMPTY_THRESH);
  localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic                 wr_acc;
  logic                 rd_acc;

  // Flags are a pure decode of the registered count, so they move on the count's edge
  // and follow an asynchronous reset immediately.
  assign full          = (count == DEPTH_C);
  assign almost_full   = (count == AFULL_C);
  assign prog_full     = (count >= PFULL_C);
  assign empty         = (count == '0);
  assign almost_empty  = (count == ONE_C);
  assign prog_empty    = (count <= PEMPTY_C);
  assign wr_data_count = count;
  assign rd_data_count = count;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      data_valid <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wr_ack     <= wr_acc;
      overflow   <= wr_en && !wr_acc;
      data_valid <= rd_acc;
      underflow  <= rd_en && !rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + ONE_C;
      end else if (rd_acc && !wr_acc) begin
        count <= count - ONE_C;
      end
    end
  end

`ifdef SYNC_FIFO_ASSERT_EN
  initial begin
    if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0)
      $fatal(1, "sync_fifo: DEPTH %0d must be a power of two >= 16", DEPTH);
    if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH - 1)
      $fatal(1, "sync_fifo: PROG_FULL_THRESH %0d out of range", PROG_FULL_THRESH);
    if (PROG_EMPTY_THRESH < 1 || PROG_EMPTY_THRESH > DEPTH - 1)
      $fatal(1, "sync_fifo: PROG_EMPTY_THRESH %0d out of range", PROG_EMPTY_THRESH);
  end

  always @(posedge clk) begin
    if (!rstn) begin
      if (wr_en || rd_en) $error("sync_fifo: request during reset");
    end else begin
      if (wr_en && full)  $error("sync_fifo: write while full");
      if (rd_en && empty) $error("sync_fifo: read while empty");
      if (count > DEPTH_C) $fatal(1, "sync_fifo: count %0d exceeds DEPTH", count);
    end
  end
`else
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for sync_fifo: vector table, directed corners, random vs queue model
module tb_sync_fifo;

  localparam int DEPTH = 2048;
  localparam int WIDTH = 32;
  localparam int PFT   = 10;
  localparam int PET   = 10;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             full, almost_full, prog_full, wr_ack, overflow;
  logic             data_valid, empty, almost_empty, prog_empty, underflow;
  logic [CW-1:0]    wr_data_count, rd_data_count;
  logic [WIDTH-1:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sync_fifo #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .PROG_FULL_THRESH(PFT), .PROG_EMPTY_THRESH(PET), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .din(din), .full(full),
    .almost_full(almost_full), .prog_full(prog_full), .wr_ack(wr_ack),
    .overflow(overflow), .wr_data_count(wr_data_count), .rd_en(rd_en),
    .dout(dout), .data_valid(data_valid), .empty(empty),
    .almost_empty(almost_empty), .prog_empty(prog_empty),
    .underflow(underflow), .rd_data_count(rd_data_count)
  );

  // Reference model: contents as a queue, last-read value, and last-cycle pulses.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ack, m_ovf, m_dv, m_uf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ack = 0; m_ovf = 0; m_dv = 0; m_uf = 0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic [WIDTH-1:0] d);
    bit wok, rok;
    wok = w && (q.size() < DEPTH);
    rok = r && (q.size() > 0);
    if (rok) m_dout = q.pop_front();
    if (wok) q.push_back(d);
    m_ack = wok; m_ovf = w && !wok;
    m_dv  = rok; m_uf  = r && !rok;
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("wr_data_count", 32'(wr_data_count), 32'(n));
    chk("rd_data_count", 32'(rd_data_count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_empty", 32'(almost_empty), 32'(n == 1));
    chk("almost_full", 32'(almost_full), 32'(n == DEPTH - 1));
    chk("prog_full", 32'(prog_full), 32'(n >= PFT));
    chk("prog_empty", 32'(prog_empty), 32'(n <= PET));
    chk("wr_ack", 32'(wr_ack), 32'(m_ack));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("data_valid", 32'(data_valid), 32'(m_dv));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("dout", dout, m_dout);
  endtask

  task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
    wr_en = w; rd_en = r; din = d;
    @(posedge clk); #1;
    model_step(w, r, d);
    check_model();
  endtask

  typedef struct {
    logic        wr, rd;
    logic [31:0] d;
    int          cnt;
    logic        emp, ae, ack, ovf, dv, uf;
    logic [31:0] dout;
  } vec_t;

  vec_t vt[8];

  initial begin
    model_reset();

    // Reset held for five cycles.
    repeat (5) @(posedge clk);
    #1;
    check_model();
    chk("rst_dout", dout, 32'h0);

    // Reset asserted mid-fill between edges must clear state at once.
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1, 0, 32'(100 + i));
    cycle(0, 1, 0);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("async_rst_count", 32'(wr_data_count), 32'h0);
    chk("async_rst_empty", 32'(empty), 32'h1);
    chk("async_rst_prog_empty", 32'(prog_empty), 32'h1);
    chk("async_rst_dout", dout, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Vector table: short hand-computed sequence from empty.
    vt[0] = '{1, 0, 32'h11, 1, 0, 1, 1, 0, 0, 0, 32'h0};
    vt[1] = '{1, 0, 32'h22, 2, 0, 0, 1, 0, 0, 0, 32'h0};
    vt[2] = '{0, 1, 32'h0,  1, 0, 1, 0, 0, 1, 0, 32'h11};
    vt[3] = '{1, 1, 32'h33, 1, 0, 1, 1, 0, 1, 0, 32'h22};
    vt[4] = '{0, 1, 32'h0,  0, 1, 0, 0, 0, 1, 0, 32'h33};
    vt[5] = '{0, 1, 32'h0,  0, 1, 0, 0, 0, 0, 1, 32'h33};
    vt[6] = '{1, 1, 32'hA5, 1, 0, 1, 1, 0, 0, 1, 32'h33};
    vt[7] = '{0, 1, 32'h0,  0, 1, 0, 0, 0, 1, 0, 32'hA5};
    for (int i = 0; i < 8; i++) begin
      wr_en = vt[i].wr; rd_en = vt[i].rd; din = vt[i].d;
      @(posedge clk); #1;
      model_step(vt[i].wr, vt[i].rd, vt[i].d);
      chk("vec_count", 32'(wr_data_count), 32'(vt[i].cnt));
      chk("vec_empty", 32'(empty), 32'(vt[i].emp));
      chk("vec_almost_empty", 32'(almost_empty), 32'(vt[i].ae));
      chk("vec_wr_ack", 32'(wr_ack), 32'(vt[i].ack));
      chk("vec_overflow", 32'(overflow), 32'(vt[i].ovf));
      chk("vec_data_valid", 32'(data_valid), 32'(vt[i].dv));
      chk("vec_underflow", 32'(underflow), 32'(vt[i].uf));
      chk("vec_dout", dout, vt[i].dout);
    end

    // Fill from empty with incrementing data, then keep writing into a full FIFO.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 0, 32'(i));
      if (i + 1 == PFT - 1) chk("prog_full_before_thresh", 32'(prog_full), 32'h0);
      if (i + 1 == PFT)     chk("prog_full_at_thresh", 32'(prog_full), 32'h1);
      if (i + 1 == DEPTH - 1) chk("almost_full_at_2047", 32'(almost_full), 32'h1);
    end
    chk("full_at_depth", 32'(full), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 32'hDEAD0000 + 32'(i));
      chk("overflow_when_full", 32'(overflow), 32'h1);
      chk("count_stuck", 32'(wr_data_count), 32'(DEPTH));
    end

    // Drain: data must come back in write order, one cycle after each read.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 1, 0);
      chk("drain_dout", dout, 32'(i));
    end
    cycle(0, 1, 0);
    chk("underflow_after_drain", 32'(underflow), 32'h1);
    chk("dout_held", dout, 32'(DEPTH - 1));

    // Full FIFO with simultaneous requests: read wins, write rejected.
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, $urandom);
    cycle(1, 1, 32'hBEEF);
    chk("full_both_overflow", 32'(overflow), 32'h1);
    chk("full_both_count", 32'(wr_data_count), 32'(DEPTH - 1));
    while (q.size() > 0) cycle(0, 1, 0);

    // Empty FIFO with simultaneous requests: write wins, read rejected.
    cycle(1, 1, 32'hA5);
    chk("empty_both_underflow", 32'(underflow), 32'h1);
    chk("empty_both_almost_empty", 32'(almost_empty), 32'h1);
    cycle(0, 1, 0);
    chk("empty_both_readback", dout, 32'hA5);

    // Random interleave across pointer wrap.
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
